// File: rtl/ldpc_3gpp_dec_cnode_mem_pkg.sv
// Shared LDPC decoder constants and strobe type used by the check-node message store.
// Column count per cycle is fixed here and is not overridable by instantiating modules.
package ldpc_3gpp_dec_cnode_mem_pkg;

  localparam int cCOL_BY_CYCLE = 2;

  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
  } strb_t;

  localparam logic [0:0] cIDLE  = 1'b0;
  localparam logic [0:0] cFRAME = 1'b1;

endpackage

// File: rtl/ldpc_3gpp_dec_cnode_mem_ram.sv
// Simple dual-port RAM: registered read, read-before-write on address collision.
// Contents are never reset.
module ldpc_3gpp_dec_cnode_mem_ram #(
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 80
) (
  input  logic               iclk,
  input  logic               iclkena,
  input  logic               iwrite,
  input  logic [pADDR_W-1:0] iwaddr,
  input  logic [pDAT_W-1:0]  iwdata,
  input  logic               iread,
  input  logic [pADDR_W-1:0] iraddr,
  output logic [pDAT_W-1:0]  ordata
);

  logic [pDAT_W-1:0] mem [2**pADDR_W];

  // Both ports in one block so a colliding read sees the pre-write word.
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (iread)  ordata       <= mem[iraddr];
      if (iwrite) mem[iwaddr] <= iwdata;
    end
  end

endmodule

// File: rtl/ldpc_3gpp_dec_cnode_mem.sv
// Check-node message store: captures a frame of check-node words at sequential
// addresses, reports frame completion/decode-fail, and serves 2-cycle reads.
module ldpc_3gpp_dec_cnode_mem
  import ldpc_3gpp_dec_cnode_mem_pkg::*;
#(
  parameter int pNODE_W       = 5,
  parameter int pLLR_BY_CYCLE = 1,
  parameter int pROW_BY_CYCLE = 8,
  parameter int pADDR_W       = 8
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               ival,
  input  strb_t              istrb,
  input  logic               idecfail,
  input  logic [pROW_BY_CYCLE-1:0][cCOL_BY_CYCLE-1:0][pLLR_BY_CYCLE-1:0][pNODE_W-1:0] icnode,
  input  logic               ird,
  input  logic [pADDR_W-1:0] irdaddr,
  output logic               ordval,
  output logic [pROW_BY_CYCLE-1:0][cCOL_BY_CYCLE-1:0][pLLR_BY_CYCLE-1:0][pNODE_W-1:0] ordata,
  output logic               odone,
  output logic [pADDR_W:0]   owords,
  output logic               odecfail,
  output logic               obusy,
  output logic               oerr
);

  localparam int cWORD_W = pROW_BY_CYCLE * cCOL_BY_CYCLE * pLLR_BY_CYCLE * pNODE_W;

  logic [0:0]         state;
  logic [pADDR_W:0]   wr_addr;
  logic               acc_fail;
  logic               full;
  logic               wr_en;
  logic [pADDR_W-1:0] waddr;
  logic [1:0]         vld_pipe;
  logic [cWORD_W-1:0] ram_rdata;
  logic               unused_strb;

  // Packet strobes carry no meaning for storage, only frame strobes do.
  assign unused_strb = istrb.sop ^ istrb.eop;

  assign full  = wr_addr[pADDR_W];
  assign wr_en = iclkena & ival & (istrb.sof | ((state == cFRAME) & ~full));
  assign waddr = istrb.sof ? '0 : wr_addr[pADDR_W-1:0];
  assign obusy = (state == cFRAME);

  ldpc_3gpp_dec_cnode_mem_ram #(
    .pADDR_W (pADDR_W),
    .pDAT_W  (cWORD_W)
  ) u_ram (
    .iclk    (iclk),
    .iclkena (iclkena),
    .iwrite  (wr_en),
    .iwaddr  (waddr),
    .iwdata  (icnode),
    .iread   (ird),
    .iraddr  (irdaddr),
    .ordata  (ram_rdata)
  );

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state    <= cIDLE;
      wr_addr  <= '0;
      acc_fail <= 1'b0;
      odone    <= 1'b0;
      owords   <= '0;
      odecfail <= 1'b0;
      oerr     <= 1'b0;
    end else if (iclkena) begin
      odone <= 1'b0;
      if (ival) begin
        if (istrb.sof) begin
          // sof always (re)starts at address 0, silently aborting any open frame
          wr_addr  <= (pADDR_W+1)'(1);
          acc_fail <= idecfail;
          oerr     <= 1'b0;
          if (istrb.eof) begin
            state    <= cIDLE;
            odone    <= 1'b1;
            owords   <= (pADDR_W+1)'(1);
            odecfail <= idecfail;
          end else begin
            state <= cFRAME;
          end
        end else if (state == cIDLE) begin
          oerr <= 1'b1;
        end else begin
          if (full) begin
            oerr <= 1'b1;
          end else begin
            wr_addr  <= wr_addr + 1'b1;
            acc_fail <= acc_fail | idecfail;
          end
          if (istrb.eof) begin
            state    <= cIDLE;
            odone    <= 1'b1;
            owords   <= full ? wr_addr : wr_addr + 1'b1;
            odecfail <= acc_fail | (idecfail & ~full);
          end
        end
      end
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      vld_pipe <= '0;
      ordata   <= '0;
    end else if (iclkena) begin
      vld_pipe <= {vld_pipe[0], ird};
      if (vld_pipe[0]) ordata <= ram_rdata;
    end
  end

  assign ordval = vld_pipe[1];

endmodule
